// File: rtl/cmd_sender_pkg.sv
// cmd_sender_pkg: shared types and constants for the host command sender.
package cmd_sender_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_CMD,
        S_TX_HI,
        S_TX_LO,
        S_WAIT_RESP
    } state_t;

    localparam int FRAME_BYTES = 3;

    localparam logic [7:0] RESP_ACK  = 8'hA5;
    localparam logic [7:0] RESP_NACK = 8'hEE;

    // Clocks per UART bit.
    localparam int BAUD_DIV = 16;

    typedef logic [$clog2(FRAME_BYTES)-1:0] bidx_t;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [15:0] data;
    } frame_t;

    function automatic logic [7:0] frame_byte(
        input frame_t f,
        input bidx_t  idx
    );
        case (idx)
            bidx_t'(0): return f.cmd;
            bidx_t'(1): return f.data[15:8];
            default:    return f.data[7:0];
        endcase
    endfunction

endpackage

// File: rtl/cmd_sender_uart.sv
// cmd_sender_uart: 8N1 UART transceiver, LSB first.
// tx_done is a level cleared by trmt; rx_rdy is held until clr_rx_rdy.
module cmd_sender_uart
    import cmd_sender_pkg::*;
#(
    parameter int DIV = BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       rx_rdy,
    output logic [7:0] rx_data,
    input  logic       clr_rx_rdy
);

    localparam int CW = $clog2(DIV);

    logic [9:0]    tx_sh;
    logic [3:0]    tx_bits;
    logic [CW-1:0] tx_cnt;
    logic          tx_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh   <= '1;
            tx_bits <= '0;
            tx_cnt  <= '0;
            tx_act  <= 1'b0;
            tx_done <= 1'b0;
        end else if (trmt) begin
            tx_sh   <= {1'b1, tx_data, 1'b0};
            tx_bits <= '0;
            tx_cnt  <= '0;
            tx_act  <= 1'b1;
            tx_done <= 1'b0;
        end else if (tx_act) begin
            if (tx_cnt == CW'(DIV - 1)) begin
                tx_cnt <= '0;
                tx_sh  <= {1'b1, tx_sh[9:1]};
                if (tx_bits == 4'd9) begin
                    tx_act  <= 1'b0;
                    tx_done <= 1'b1;
                end else begin
                    tx_bits <= tx_bits + 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    assign TX = tx_sh[0];

    logic          rx_s1;
    logic          rx_s2;
    logic          rx_act;
    logic [3:0]    rx_bits;
    logic [CW-1:0] rx_cnt;
    logic [7:0]    rx_sh;
    logic          rx_tick;
    logic          rx_fin;

    assign rx_tick = rx_act && (rx_cnt == CW'(DIV - 1));
    assign rx_fin  = rx_tick && (rx_bits == 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
        end
    end

    // Half-bit preload puts every sample near mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_act  <= 1'b0;
            rx_bits <= '0;
            rx_cnt  <= '0;
            rx_sh   <= '0;
        end else if (!rx_act) begin
            if (!rx_s2) begin
                rx_act  <= 1'b1;
                rx_bits <= '0;
                rx_cnt  <= CW'(DIV / 2);
            end
        end else if (rx_tick) begin
            rx_cnt  <= '0;
            rx_bits <= rx_bits + 4'd1;
            if (rx_bits == 4'd0) begin
                if (rx_s2) rx_act <= 1'b0;
            end else if (rx_bits == 4'd9) begin
                rx_act <= 1'b0;
            end else begin
                rx_sh <= {rx_s2, rx_sh[7:1]};
            end
        end else begin
            rx_cnt <= rx_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_rdy  <= 1'b0;
            rx_data <= '0;
        end else if (rx_fin) begin
            rx_rdy  <= 1'b1;
            rx_data <= rx_sh;
        end else if (clr_rx_rdy) begin
            rx_rdy <= 1'b0;
        end
    end

endmodule

// File: rtl/cmd_sender.sv
// cmd_sender: sends {cmd, data_hi, data_lo} over UART, then awaits one reply.
// Define RESP_TIMEOUT_EN to give up on a missing reply after TO_CYCLES.
module cmd_sender
    import cmd_sender_pkg::*;
#(
    parameter int TO_CYCLES = 1_000_000,
    parameter int TO_W      = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    input  logic        send_cmd,
    input  logic        clr_resp_rdy,
    output logic        busy,
    output logic        cmd_sent,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    output logic        timeout
);

    if ((64'd1 << TO_W) < 64'(TO_CYCLES)) begin : g_to_w_chk
        $error("TO_W too narrow for TO_CYCLES");
    end

    logic       trmt;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       clr_rx_rdy;

    cmd_sender_uart u_uart (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (RX),
        .TX        (TX),
        .trmt      (trmt),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .clr_rx_rdy(clr_rx_rdy)
    );

    state_t state;
    state_t state_nxt;
    frame_t hold;
    frame_t frame_src;
    bidx_t  tx_idx;
    logic   tx_load;
    logic   accept;
    logic   tx_last;
    logic   got_resp;
    logic   tx_go;
    logic   to_exp;

    // tx_done still shows the previous byte while trmt is in flight.
    assign tx_go      = tx_done & ~trmt;
    assign clr_rx_rdy = rx_rdy;
    assign busy       = (state != S_IDLE);
    assign frame_src  = accept ? {cmd, data} : hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_idx    = bidx_t'(0);
        tx_load   = 1'b0;
        accept    = 1'b0;
        tx_last   = 1'b0;
        got_resp  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (send_cmd) begin
                    accept    = 1'b1;
                    tx_load   = 1'b1;
                    state_nxt = S_TX_CMD;
                end
            end
            S_TX_CMD: begin
                if (tx_go) begin
                    tx_idx    = bidx_t'(1);
                    tx_load   = 1'b1;
                    state_nxt = S_TX_HI;
                end
            end
            S_TX_HI: begin
                if (tx_go) begin
                    tx_idx    = bidx_t'(2);
                    tx_load   = 1'b1;
                    state_nxt = S_TX_LO;
                end
            end
            S_TX_LO: begin
                if (tx_go) begin
                    tx_last   = 1'b1;
                    state_nxt = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (rx_rdy) begin
                    got_resp  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (to_exp) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold     <= '0;
            tx_data  <= '0;
            trmt     <= 1'b0;
            cmd_sent <= 1'b0;
            resp     <= '0;
            resp_rdy <= 1'b0;
        end else begin
            trmt     <= tx_load;
            cmd_sent <= tx_last;
            if (accept)   hold    <= frame_src;
            if (tx_load)  tx_data <= frame_byte(frame_src, tx_idx);
            if (got_resp) resp    <= rx_data;
            if (clr_resp_rdy)  resp_rdy <= 1'b0;
            else if (got_resp) resp_rdy <= 1'b1;
            else if (accept)   resp_rdy <= 1'b0;
        end
    end

`ifdef RESP_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            to_q;
    logic            to_hit;

    assign to_exp  = (to_cnt == TO_W'(TO_CYCLES - 1));
    assign to_hit  = (state == S_WAIT_RESP) & ~rx_rdy & to_exp;
    assign timeout = to_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
            to_q   <= 1'b0;
        end else begin
            if (tx_last)
                to_cnt <= '0;
            else if (state == S_WAIT_RESP)
                to_cnt <= to_cnt + 1'b1;
            if (accept)      to_q <= 1'b0;
            else if (to_hit) to_q <= 1'b1;
        end
    end
`else
    assign to_exp  = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule
